// File: rtl/adder_accumulator.sv
// adder_accumulator: accumulates a group of operand beats through a single
// full_adder and presents the sum, a sticky carry flag and the beat count
// once the group's last beat has been accepted.
//
// Optional feature: define ACCUM_SAT_EN to saturate the accumulator at all
// ones on overflow instead of wrapping modulo 2^BIT_WIDTH.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   block accepts an operand beat (IDLE/ACC)
//   in_data    operand value, BIT_WIDTH bits
//   in_last    beat is the final operand of the group
//   out_valid  accumulated result valid (HOLD)
//   out_ready  downstream accepts the result
//   out_sum    accumulated sum, BIT_WIDTH bits
//   out_carry  sticky: any carry-out occurred in the group
//   out_count  beats accepted in the group, saturating, COUNT_WIDTH bits

module full_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned SUM_W = WIDTH + 1;

  // One extra bit captures the carry-out.
  always_comb begin
    {cout, sum} = SUM_W'(a) + SUM_W'(b) + SUM_W'(cin);
  end

endmodule

module adder_accumulator #(
  parameter int unsigned BIT_WIDTH   = 4,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BIT_WIDTH-1:0]   in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BIT_WIDTH-1:0]   out_sum,
  output logic                   out_carry,
  output logic [COUNT_WIDTH-1:0] out_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
`ifdef ACCUM_SAT_EN
  localparam logic [BIT_WIDTH-1:0]   ACC_MAX   = '1;
`endif

  state_t                 state_q, state_d;
  logic [BIT_WIDTH-1:0]   acc_q, acc_d;
  logic                   carry_q, carry_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;

  logic [BIT_WIDTH-1:0]   add_sum;
  logic                   add_cout;
  logic                   accept;

  // Single shared adder: accumulator plus incoming operand.
  full_adder #(
    .WIDTH (BIT_WIDTH)
  ) u_adder (
    .a    (acc_q),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // in_ready_q is low only in HOLD, so this also gates out HOLD.
  assign accept = in_valid && in_ready_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    count_d  = count_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = in_data;
          carry_d = 1'b0;
          count_d = COUNT_WIDTH'(1);
          state_d = in_last ? HOLD : ACC;
        end
      end
      ACC: begin
        if (accept) begin
`ifdef ACCUM_SAT_EN
          acc_d = add_cout ? ACC_MAX : add_sum;
`else
          acc_d = add_sum;
`endif
          carry_d = carry_q | add_cout;
          count_d = (count_q == COUNT_MAX) ? count_q : count_q + COUNT_WIDTH'(1);
          state_d = in_last ? HOLD : ACC;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake flags registered alongside the state they decode.
    in_ready_d  = (state_d != HOLD);
    out_valid_d = (state_d == HOLD);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_carry = carry_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_adder_accumulator.sv
// Self-checking bench for adder_accumulator: directed groups plus random
// groups, compared against a plain-arithmetic model of each group.

module tb_adder_accumulator;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 8;
  localparam int MAXV = (1 << W) - 1;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_carry;
  logic [CW-1:0] out_count;

  int compared   = 0;
  int mismatched = 0;

  // Model: beats of the current/last group and whether a result is pending.
  int grp[$];
  bit in_group;
  bit holding;

  always #5 clk = ~clk;

  adder_accumulator #(
    .BIT_WIDTH   (W),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_count (out_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sum of a group with plain integers: wrap (or clamp) after each add.
  function automatic void ref_model(input int q[$], output int sum, output int carry,
                                    output int cnt);
    sum   = 0;
    carry = 0;
    foreach (q[i]) begin
      if (i == 0) begin
        sum = q[0];
      end else if (sum + q[i] > MAXV) begin
        carry = 1;
`ifdef ACCUM_SAT_EN
        sum = MAXV;
`else
        sum = sum + q[i] - (MAXV + 1);
`endif
      end else begin
        sum = sum + q[i];
      end
    end
    cnt = (q.size() > CMAX) ? CMAX : q.size();
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    int s, c, n;
    ref_model(grp, s, c, n);
    check({tag, "_sum"},   32'(out_sum),   32'(s));
    check({tag, "_carry"}, 32'(out_carry), 32'(c));
    check({tag, "_count"}, 32'(out_count), 32'(n));
    check({tag, "_ready"}, 32'(in_ready),  32'(!holding));
    check({tag, "_valid"}, 32'(out_valid), 32'(holding));
  endtask

  task automatic send_beat(input int d, input bit last);
    in_valid = 1'b1;
    in_data  = W'(d);
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!in_group) grp.delete();
    grp.push_back(d);
    in_group = !last;
    holding  = last;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    holding = 1'b0;
    check_all("release");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    grp.delete();
    in_group = 1'b0;
    holding  = 1'b0;
    check_all("reset");
  endtask

  task automatic gap_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_last  = 1'b1;
      in_data  = W'($urandom);
      step();
      check_all("gap");
    end
    in_last = 1'b0;
  endtask

  initial begin
    int len;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    grp.delete();
    in_group  = 1'b0;
    holding   = 1'b0;

    step();
    step();
    rst = 1'b0;
    check_all("por");

    // Three-beat group, result one cycle after the last accept.
    send_beat(3, 0); check_all("g031_b");
    send_beat(4, 0); check_all("g031_b");
    send_beat(5, 1); check_all("g031_last");
    check("g031_sum_const", 32'(out_sum), 32'd12);
    check("g031_count_const", 32'(out_count), 32'd3);
    release_result();

    // Overflowing group.
    send_beat(9, 0);
    send_beat(8, 1); check_all("g032");
`ifdef ACCUM_SAT_EN
    check("g032_sum_const", 32'(out_sum), 32'd15);
`else
    check("g032_sum_const", 32'(out_sum), 32'd1);
`endif
    check("g032_carry_const", 32'(out_carry), 32'd1);
    release_result();

    // Single last beat from IDLE.
    send_beat(7, 1); check_all("g033");
    check("g033_count_const", 32'(out_count), 32'd1);
    release_result();

    // Back-pressure: result held, new beats refused while waiting.
    send_beat(2, 0);
    send_beat(2, 1);
    in_valid = 1'b1;
    in_data  = W'(5);
    in_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_all("g034_hold");
    end
    check("g034_sum_const", 32'(out_sum), 32'd4);
    release_result();
    check("g034_no_early_accept", 32'(out_count), 32'd2);
    in_valid = 1'b0;
    step();
    check_all("g034_after");

    // Reset aborts a group mid-way.
    send_beat(6, 0);
    send_beat(6, 0); check_all("g035_acc");
    do_reset();
    send_beat(2, 1); check_all("g035_after");
    release_result();

    // Gaps with in_last high but in_valid low are ignored.
    send_beat(1, 0);
    gap_cycles(3);
    send_beat(1, 1); check_all("g036");
    check("g036_sum_const", 32'(out_sum), 32'd2);
    release_result();

    // Reset wins over a simultaneous result handshake and beat.
    send_beat(4, 1);
    rst       = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = W'(3);
    step();
    rst       = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    grp.delete();
    in_group = 1'b0;
    holding  = 1'b0;
    check_all("rst_prio");

    // Random groups with random gaps and back-pressure.
    for (int g = 0; g < 25; g++) begin
      len = int'($urandom_range(1, 6));
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) gap_cycles(int'($urandom_range(1, 2)));
        send_beat(int'($urandom_range(0, MAXV)), b == len - 1);
        check_all("rnd_beat");
      end
      for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
        step();
        check_all("rnd_hold");
      end
      release_result();
    end

    // Beat counter saturates rather than wrapping.
    for (int b = 0; b < CMAX + 20; b++) begin
      send_beat(int'($urandom_range(0, 2)), b == CMAX + 19);
    end
    check_all("sat_count");
    check("sat_count_const", 32'(out_count), 32'(CMAX));
    release_result();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
